emitter_stream_fifo: RTL

EMITTER_STREAM_FIFO -- requirements
Module: emitter_stream_fifo

---
 rtl/emitter_stream_fifo_if.sv | 22 ++
 rtl/emitter_fifo_ram.sv | 20 ++
 rtl/emitter_stream_fifo.sv | 106 ++++++++++
 3 files changed

// File: rtl/emitter_stream_fifo_if.sv
// Producer stream plus CPU read-strobe bus of the emitter FIFO.
// master drives bytes and strobes; slave is the FIFO side.
interface emitter_stream_fifo_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       wb_stb;
   logic       wb_sel;
   logic [9:0] wb_rdt;
   logic       wb_ack;
   logic       overflow;

   modport master (
      output tdata, tvalid, wb_stb, wb_sel,
      input  tready, wb_rdt, wb_ack, overflow
   );

   modport slave (
      input  tdata, tvalid, wb_stb, wb_sel,
      output tready, wb_rdt, wb_ack, overflow
   );
endinterface

// File: rtl/emitter_fifo_ram.sv
// Simple dual-port byte store: one synchronous write port, asynchronous read.
// Contents are intentionally left unreset.
module emitter_fifo_ram #(
   parameter int AW = 4
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/emitter_stream_fifo.sv
// Byte FIFO between a valid/ready producer and a CPU strobe/ack read port.
// Data reads pop one byte; status reads report full/empty/overflow/count and clear overflow.
module emitter_stream_fifo #(
   parameter int AW = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_tdata,
   input  logic       i_tvalid,
   output logic       o_tready,
   input  logic       i_wb_stb,
   input  logic       i_wb_sel,
   output logic [9:0] o_wb_rdt,
   output logic       o_wb_ack,
   output logic       o_overflow
);
   localparam int          DEPTH     = 1 << AW;
   localparam int          CNT_W     = 7;
   localparam int          RDT_FULL  = 9;
   localparam int          RDT_EMPTY = 8;
   localparam int          RDT_OVF   = 7;
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_ack;
   logic              r_overflow;
   logic [9:0]        r_rdt;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_start;
   logic              w_pop;
   logic [7:0]        w_rd_data;
   logic [AW+CNT_W:0] w_cnt_ext;
   logic [9:0]        w_status;

   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign o_tready = !w_full;
   assign w_push   = i_tvalid & !w_full;
   // Strobe held during the ack cycle must not launch a second read.
   assign w_start  = i_wb_stb & !r_ack;
   assign w_pop    = w_start & !i_wb_sel & !w_empty;

   assign w_cnt_ext = {{CNT_W{1'b0}}, r_count};

   always_comb begin
      w_status            = '0;
      w_status[RDT_FULL]  = w_full;
      w_status[RDT_EMPTY] = w_empty;
      w_status[RDT_OVF]   = r_overflow;
      w_status[CNT_W-1:0] = w_cnt_ext[CNT_W-1:0];
   end

   emitter_fifo_ram #(.AW(AW)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_tdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ack <= 1'b0;
         r_rdt <= '0;
      end else begin
         r_ack <= w_start;
         if (w_start) begin
            if (i_wb_sel) r_rdt <= w_status;
            else          r_rdt <= {!w_empty, 1'b0, w_rd_data};
         end
      end
   end

   // A drop on the same edge as a status read keeps the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst)                       r_overflow <= 1'b0;
      else if (i_tvalid & w_full)      r_overflow <= 1'b1;
      else if (w_start & i_wb_sel)     r_overflow <= 1'b0;
   end

   assign o_wb_rdt   = r_rdt;
   assign o_wb_ack   = r_ack;
   assign o_overflow = r_overflow;
endmodule
